uart_transmitter: RTL

UART_TRANSMITTER -- requirements
Module: uart_transmitter

---
 rtl/uart_pkg.sv | 31 +++
 rtl/uart_tx_baud_gen.sv | 41 ++++
 rtl/uart_transmitter.sv | 111 +++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encodings, oversampling ratio and the
// baud divisor table helper, common to the transmitter and receiver.
package uart_pkg;

  localparam int unsigned OVERSAMPLE     = 16;
  localparam int unsigned DIV_W          = 16;
  localparam int unsigned DATA_BITS_N    = 8;
  localparam int unsigned DATA_LAST_TICK = (1 + DATA_BITS_N) * OVERSAMPLE - 1;

  typedef logic [2:0]       uart_state_t;
  typedef logic [DIV_W-1:0] baud_div_t;

  localparam uart_state_t IDLE       = 3'd0;
  localparam uart_state_t START_BIT  = 3'd1;
  localparam uart_state_t DATA_BITS  = 3'd2;
  localparam uart_state_t PARITY_BIT = 3'd3;
  localparam uart_state_t STOP_BIT   = 3'd4;

  localparam int unsigned BAUD_RATE [8] = '{300, 1200, 4800, 9600, 19200, 38400, 57600, 115200};

  // Divisor rounded to nearest; clamped to 1 so slow clocks still tick every cycle.
  function automatic baud_div_t baud_div(input int unsigned clk_hz, input logic [2:0] sel);
    int unsigned rate;
    int unsigned d;
    rate = BAUD_RATE[sel];
    d = (clk_hz + (OVERSAMPLE / 2) * rate) / (OVERSAMPLE * rate);
    if (d == 0) d = 1;
    return baud_div_t'(d);
  endfunction

endpackage

// File: rtl/uart_tx_baud_gen.sv
// 16x-baud tick generator; the divisor is latched on restart so a frame keeps
// its rate even if baud_select moves mid-frame.
module uart_tx_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] baud_select,
  input  logic       restart,
  output logic       tick
);

  localparam baud_div_t DIV_TABLE [8] = '{
    baud_div(CLK_HZ, 3'd0), baud_div(CLK_HZ, 3'd1),
    baud_div(CLK_HZ, 3'd2), baud_div(CLK_HZ, 3'd3),
    baud_div(CLK_HZ, 3'd4), baud_div(CLK_HZ, 3'd5),
    baud_div(CLK_HZ, 3'd6), baud_div(CLK_HZ, 3'd7)
  };

  baud_div_t div_q;
  baud_div_t cnt;

  assign tick = (cnt == div_q - 1'b1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q <= '0;
      cnt   <= '0;
    end else if (restart) begin
      div_q <= DIV_TABLE[baud_select];
      cnt   <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: start, 8 data bits MSB first, odd parity, stop; every bit
// held for 16 ticks of the 16x-baud generator. TxD and Tx_BUSY are registered.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] Tx_DATA,
  input  logic [2:0] baud_select,
  input  logic       Tx_EN,
  input  logic       Tx_WR,
  output logic       TxD,
  output logic       Tx_BUSY
);

  uart_state_t state;
  logic [7:0]  tick_cnt;
  logic [7:0]  shreg;
  logic        parity;
  logic        tick;
  logic        accept;
  logic        bit_end;

  assign accept  = (state == IDLE) && Tx_WR && Tx_EN;
  assign bit_end = tick && (tick_cnt[3:0] == 4'(OVERSAMPLE - 1));

  uart_tx_baud_gen #(
    .CLK_HZ(CLK_HZ)
  ) u_baud_gen (
    .clk        (clk),
    .reset      (reset),
    .baud_select(baud_select),
    .restart    (accept),
    .tick       (tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      TxD      <= 1'b1;
      Tx_BUSY  <= 1'b0;
      shreg    <= '0;
      parity   <= 1'b0;
      tick_cnt <= '0;
    end else if ((state != IDLE) && !Tx_EN) begin
      state    <= IDLE;
      TxD      <= 1'b1;
      Tx_BUSY  <= 1'b0;
      tick_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          TxD <= 1'b1;
          if (accept) begin
            state    <= START_BIT;
            TxD      <= 1'b0;
            Tx_BUSY  <= 1'b1;
            shreg    <= Tx_DATA;
            parity   <= ~^Tx_DATA;
            tick_cnt <= '0;
          end
        end
        START_BIT: begin
          if (tick) tick_cnt <= tick_cnt + 8'd1;
          if (bit_end) begin
            state <= DATA_BITS;
            TxD   <= shreg[7];
          end
        end
        DATA_BITS: begin
          if (tick) tick_cnt <= tick_cnt + 8'd1;
          // tick_cnt spans the whole frame; the last data bit ends at tick 143.
          if (bit_end) begin
            if (tick_cnt == 8'(DATA_LAST_TICK)) begin
              state <= PARITY_BIT;
              TxD   <= parity;
            end else begin
              shreg <= {shreg[6:0], 1'b0};
              TxD   <= shreg[6];
            end
          end
        end
        PARITY_BIT: begin
          if (tick) tick_cnt <= tick_cnt + 8'd1;
          if (bit_end) begin
            state <= STOP_BIT;
            TxD   <= 1'b1;
          end
        end
        STOP_BIT: begin
          if (tick) tick_cnt <= tick_cnt + 8'd1;
          if (bit_end) begin
            state    <= IDLE;
            TxD      <= 1'b1;
            Tx_BUSY  <= 1'b0;
            tick_cnt <= '0;
          end
        end
        default: begin
          state    <= IDLE;
          TxD      <= 1'b1;
          Tx_BUSY  <= 1'b0;
          tick_cnt <= '0;
        end
      endcase
    end
  end

endmodule
